// File: rtl/pulse_blinker_pkg.sv
// pulse_blinker_pkg: state encoding and sizing helper shared by the blinker files
package pulse_blinker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } blink_state_t;

    // Width needed to hold the larger of two cycle counts
    function automatic int clog2max(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer: loadable down-counter, done while the count sits at zero
module blink_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load on state entry, otherwise count down and park at zero (never wraps)
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pulse_blinker.sv
// pulse_blinker: turns one-cycle event strobes into queued, fixed-length LED blinks
module pulse_blinker
    import pulse_blinker_pkg::*;
#(
    parameter  int ON_CYC   = 5_000_000,
    parameter  int OFF_CYC  = 5_000_000,
    parameter  int MAX_PEND = 15,
    localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt,
    input  logic             clr_ovf,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int               TMR_W    = clog2max(ON_CYC, OFF_CYC);
    localparam logic [TMR_W-1:0] ON_LD    = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] OFF_LD   = TMR_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_TOP = CNT_W'(MAX_PEND);

    blink_state_t     state, state_d;
    logic             load, done, has_pend, full, inc, dec, drop;
    logic [TMR_W-1:0] load_val;
    logic [CNT_W-1:0] pending_d;

    blink_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    assign has_pend = (pending != '0);
    assign full     = (pending == PEND_TOP);

    // Next state, timer loads on state entry, and queue accounting
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_val = ON_LD;
        dec      = 1'b0;
        case (state)
            IDLE: begin
                if (has_pend || evt) begin
                    state_d = ON;
                    load    = 1'b1;
                    dec     = has_pend;
                end
            end
            ON: begin
                if (done) begin
                    state_d  = GAP;
                    load     = 1'b1;
                    load_val = OFF_LD;
                end
            end
            GAP: begin
                if (done) begin
                    state_d = has_pend ? ON : IDLE;
                    load    = has_pend;
                    dec     = has_pend;
                end
            end
            default: state_d = IDLE;
        endcase
        // An event starts a blink directly only from an empty idle; otherwise it is queued
        inc       = evt && !(state == IDLE && !has_pend);
        drop      = inc && !dec && full;
        pending_d = (inc && !dec && !full) ? pending + CNT_W'(1) :
                    (dec && !inc)          ? pending - CNT_W'(1) : pending;
    end

    // State, queue and registered outputs; reset discards any blink in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            pending  <= pending_d;
            overflow <= drop | (overflow & ~clr_ovf);
            led      <= (state_d == ON);
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_blinker.sv
// tb_pulse_blinker: directed scenarios with a cycle-stamped expectation queue
module tb_pulse_blinker;

    localparam int ON_CYC   = 4;
    localparam int OFF_CYC  = 3;
    localparam int MAX_PEND = 2;
    localparam int PERIOD   = ON_CYC + OFF_CYC;

    typedef struct {
        string      tag;
        int         cyc;
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, evt = 1'b0, clr_ovf = 1'b0;
    logic       led, busy, overflow;
    logic [1:0] pending;

    exp_t sb[$];
    int   cyc = 0, base = 0, n_cmp = 0, n_bad = 0;
    logic mon_en = 1'b0, led_prev = 1'b0, seen_hi = 1'b0;
    int   hi_run = 0, lo_run = 0;

    pulse_blinker #(.ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .MAX_PEND(MAX_PEND)) dut (
        .clk      (clk),
        .rst      (rst),
        .evt      (evt),
        .clr_ovf  (clr_ovf),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop every expectation stamped for this cycle and compare
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            assert ({led, busy, pending, overflow} === {e.led, e.busy, e.pend, e.ovf})
            else begin
                n_bad++;
                $error("FAIL %s cyc %0d: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                       e.tag, e.cyc, led, busy, pending, overflow, e.led, e.busy, e.pend, e.ovf);
            end
        end
    end

    // Blink shape monitor: bounded high runs, minimum low gaps between blinks
    always @(negedge clk) begin
        if (mon_en) begin
            if (led) begin
                if (!led_prev && seen_hi) begin
                    n_cmp++;
                    assert (lo_run >= OFF_CYC)
                    else begin
                        n_bad++;
                        $error("FAIL gap_len: got %0d low cycles, want >= %0d", lo_run, OFF_CYC);
                    end
                end
                hi_run++;
                lo_run  = 0;
                seen_hi = 1'b1;
            end else begin
                if (led_prev) begin
                    n_cmp++;
                    assert (hi_run <= ON_CYC)
                    else begin
                        n_bad++;
                        $error("FAIL on_len: got %0d high cycles, want <= %0d", hi_run, ON_CYC);
                    end
                end
                hi_run = 0;
                lo_run++;
            end
            led_prev = led;
        end else begin
            hi_run   = 0;
            lo_run   = 0;
            seen_hi  = 1'b0;
            led_prev = 1'b0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic void push(string tag, int k, bit l, bit b, int p, bit o);
        exp_t e;
        e.tag  = tag;
        e.cyc  = base + k;
        e.led  = l;
        e.busy = b;
        e.pend = 2'(p);
        e.ovf  = o;
        sb.push_back(e);
    endfunction

    // LED expected high inside the ON window of any of n blinks starting at first
    function automatic bit lit(int k, int first, int n);
        return k >= first && k < first + PERIOD * n && (k - first) % PERIOD < ON_CYC;
    endfunction

    function automatic bit act(int k, int first, int n);
        return k >= first && k < first + PERIOD * n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        base = cyc;
        push("reset", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1. Single event
        base = cyc;
        for (int k = 0; k <= 9; k++)
            push("single", k, lit(k, 1, 1), act(k, 1, 1), 0, 0);
        for (int k = 0; k <= 9; k++) begin
            evt = (k == 0);
            tick();
        end
        evt = 1'b0;

        // 2. Queued events at 0, 2, 3
        base = cyc;
        for (int k = 0; k <= 23; k++)
            push("queued", k, lit(k, 1, 3), act(k, 1, 3),
                 k < 3 ? 0 : k < 4 ? 1 : k < 8 ? 2 : k < 15 ? 1 : 0, 0);
        for (int k = 0; k <= 23; k++) begin
            evt = (k == 0 || k == 2 || k == 3);
            tick();
        end
        evt = 1'b0;

        // 3. Saturation and overflow clear
        base = cyc;
        for (int k = 0; k <= 24; k++)
            push("saturate", k, lit(k, 1, 3), act(k, 1, 3),
                 k < 2 ? 0 : k < 3 ? 1 : k < 8 ? 2 : k < 15 ? 1 : 0, k >= 4 && k <= 10);
        for (int k = 0; k <= 24; k++) begin
            evt     = (k <= 3);
            clr_ovf = (k == 10);
            tick();
        end
        evt     = 1'b0;
        clr_ovf = 1'b0;

        // 4. Event on dequeue cycle; drop coinciding with clr_ovf
        base = cyc;
        for (int k = 0; k <= 30; k++)
            push("simul", k, lit(k, 1, 4), act(k, 1, 4),
                 k < 2 ? 0 : k < 10 ? 1 : k < 15 ? 2 : k < 22 ? 1 : 0, k == 11 || k == 12);
        for (int k = 0; k <= 30; k++) begin
            evt     = (k == 0 || k == 1 || k == 7 || k == 9 || k == 10);
            clr_ovf = (k == 10 || k == 12);
            tick();
        end
        evt     = 1'b0;
        clr_ovf = 1'b0;

        // 5. Reset mid-blink with a full queue and overflow set
        base = cyc;
        for (int k = 0; k <= 16; k++)
            push("midreset", k, (k < 5 && lit(k, 1, 1)) || lit(k, 8, 1),
                 (k < 5 && act(k, 1, 1)) || act(k, 8, 1),
                 (k >= 5 || k < 2) ? 0 : k < 3 ? 1 : 2, k == 4);
        for (int k = 0; k <= 16; k++) begin
            evt = (k <= 3 || k == 7);
            rst = (k == 4);
            tick();
        end
        evt = 1'b0;
        rst = 1'b0;

        // 6. Continuous events for 20 cycles
        base   = cyc;
        mon_en = 1'b1;
        for (int k = 0; k <= 37; k++)
            push("stream", k, lit(k, 1, 5), act(k, 1, 5),
                 k < 2 ? 0 : k < 3 ? 1 : k < 22 ? 2 : k < 29 ? 1 : 0, k >= 4);
        for (int k = 0; k <= 37; k++) begin
            evt = (k < 20);
            tick();
        end
        evt    = 1'b0;
        mon_en = 1'b0;
        tick();

        n_cmp++;
        assert (sb.size() == 0)
        else begin
            n_bad++;
            $error("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
